// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and default frame constants.
package uart_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int OVERSAMPLE_DEF = 16;
   typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11} rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous RX line, resets to idle-high.
module uart_rx_sync (
   input  logic i_CLK,
   input  logic i_RESET,
   input  logic i_D,
   output logic o_Q
);
   logic meta;
   always_ff @(posedge i_CLK)
      if (!i_RESET) {o_Q, meta} <= 2'b11;
      else {o_Q, meta} <= {meta, i_D};
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 deserialiser advancing on an oversample tick; strobes good bytes and bad stop bits.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic                  i_CLK,
   input  logic                  i_RESET,
   input  logic                  i_CLK_ENABLE,
   input  logic                  i_RX,
   output logic [DATA_WIDTH-1:0] o_DATA_OUT,
   output logic                  o_DATA_VALID,
   output logic                  o_FRAME_ERROR,
   output logic                  o_RX_BUSY
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] MID = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   rx_state_t             state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [BW-1:0]         bit_cnt, bit_n;
   logic [DATA_WIDTH-1:0] shift, shift_n, data_n;
   logic                  prev, prev_n, valid_n, err_n, rx_s;

   uart_rx_sync u_sync (.i_CLK(i_CLK), .i_RESET(i_RESET), .i_D(i_RX), .o_Q(rx_s));

   always_ff @(posedge i_CLK)
      if (!i_RESET) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_cnt       <= '0;
         shift         <= '0;
         prev          <= 1'b1;
         o_DATA_OUT    <= '0;
         o_DATA_VALID  <= 1'b0;
         o_FRAME_ERROR <= 1'b0;
         o_RX_BUSY     <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         bit_cnt       <= bit_n;
         shift         <= shift_n;
         prev          <= prev_n;
         o_DATA_OUT    <= data_n;
         o_DATA_VALID  <= valid_n;
         o_FRAME_ERROR <= err_n;
         o_RX_BUSY     <= state_n != IDLE;
      end

   // Everything but the strobes holds unless a tick is present.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bit_n   = bit_cnt;
      shift_n = shift;
      prev_n  = prev;
      data_n  = o_DATA_OUT;
      valid_n = 1'b0;
      err_n   = 1'b0;
      if (i_CLK_ENABLE) begin
         prev_n = rx_s;
         cnt_n  = cnt + CW'(1);
         case (state)
            IDLE: begin
               cnt_n = '0;
               if (prev && !rx_s) state_n = START;
            end
            START:
               if (cnt == MID) begin
                  cnt_n   = '0;
                  bit_n   = '0;
                  state_n = rx_s ? IDLE : DATA;
               end
            DATA:
               if (cnt == LAST) begin
                  cnt_n   = '0;
                  shift_n = {rx_s, shift[DATA_WIDTH-1:1]};
                  bit_n   = bit_cnt + BW'(1);
                  if (bit_cnt == LAST_BIT) state_n = STOP;
               end
            STOP:
               if (cnt == LAST) begin
                  cnt_n   = '0;
                  state_n = IDLE;
                  data_n  = rx_s ? shift : o_DATA_OUT;
                  valid_n = rx_s;
                  err_n   = !rx_s;
               end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench; a line driver queues expected bytes/errors, a monitor checks strobes.
module tb_uart_receiver;
   logic       clk = 0, rst = 0, en = 0, rx = 1, jitter = 0;
   logic [7:0] data_out;
   logic       valid, ferr, busy;
   int         total = 0, bad = 0, busy_ticks = 0;
   logic [7:0] last_good = 8'h00;

   typedef struct {bit err; logic [7:0] data;} exp_t;
   exp_t exp_q[$];

   uart_receiver dut (
      .i_CLK(clk), .i_RESET(rst), .i_CLK_ENABLE(en), .i_RX(rx),
      .o_DATA_OUT(data_out), .o_DATA_VALID(valid), .o_FRAME_ERROR(ferr), .o_RX_BUSY(busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      int g;
      g = jitter ? int'($urandom_range(1, 3)) : 2;
      repeat (g - 1) begin
         @(posedge clk);
         #1 en = 0;
      end
      @(posedge clk);
      #1 en = 1;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         while (!en) @(posedge clk);
      end
   endtask

   task automatic rx_bit(input logic v);
      #1 rx = v;
      wait_ticks(16);
   endtask

   task automatic send(input logic [7:0] b, input bit stop);
      exp_q.push_back('{err: !stop, data: b});
      rx_bit(1'b0);
      for (int i = 0; i < 8; i++) rx_bit(b[i]);
      rx_bit(stop);
   endtask

   always @(negedge clk) begin
      if (busy && en) busy_ticks++;
      if (!rst) last_good = 8'h00;
      else if (valid || ferr) begin
         chk("strobe_exclusive", {31'd0, valid && ferr}, 0);
         chk("busy_low_at_strobe", {31'd0, busy}, 0);
         if (exp_q.size() == 0) chk("unexpected_strobe", {30'd0, valid, ferr}, 0);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("strobe_kind", {31'd0, ferr}, {31'd0, e.err});
            if (e.err) chk("data_kept_on_error", {24'd0, data_out}, {24'd0, last_good});
            else begin
               chk("data", {24'd0, data_out}, {24'd0, e.data});
               last_good = e.data;
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_data", {24'd0, data_out}, 0);
      chk("rst_valid", {31'd0, valid}, 0);
      chk("rst_ferr", {31'd0, ferr}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      #1 rst = 1;
      wait_ticks(20);
      send(8'hA5, 1);
      chk("a5_drained", exp_q.size(), 0);
      chk("a5_out", {24'd0, data_out}, 32'hA5);
      rx_bit(1'b1);
      busy_ticks = 0;
      #1 rx = 0;
      wait_ticks(4);
      #1 rx = 1;
      wait_ticks(30);
      chk("glitch_busy_len", {31'd0, busy_ticks >= 7 && busy_ticks <= 8}, 1);
      chk("glitch_busy_end", {31'd0, busy}, 0);
      chk("glitch_out_kept", {24'd0, data_out}, 32'hA5);
      send(8'h3C, 0);
      wait_ticks(200);
      chk("stuck_low_idle", {31'd0, busy}, 0);
      chk("ferr_drained", exp_q.size(), 0);
      chk("ferr_out_kept", {24'd0, data_out}, 32'hA5);
      rx_bit(1'b1);
      send(8'h00, 1);
      send(8'hFF, 1);
      chk("b2b_drained", exp_q.size(), 0);
      rx_bit(1'b0);
      for (int i = 0; i < 3; i++) rx_bit(1'b0 ^ (i == 0) ^ (i == 2) ^ 1'b1);
      #1 rx = 1'b1;
      wait_ticks(8);
      #1 rst = 0;
      rx = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("mid_rst_data", {24'd0, data_out}, 0);
      chk("mid_rst_valid", {31'd0, valid}, 0);
      chk("mid_rst_busy", {31'd0, busy}, 0);
      #1 rst = 1;
      wait_ticks(20);
      send(8'h81, 1);
      chk("after_rst_out", {24'd0, data_out}, 32'h81);
      rx_bit(1'b1);
      for (int i = 0; i < 10; i++) begin
         logic [7:0] b;
         bit s;
         b = 8'($urandom);
         s = $urandom_range(0, 4) != 0;
         send(b, s);
         if (!s) rx_bit(1'b1);
         wait_ticks($urandom_range(0, 20));
      end
      jitter = 1;
      rx_bit(1'b1);
      send(8'h00, 1);
      send(8'h55, 1);
      send(8'hAA, 1);
      send(8'hFF, 1);
      rx_bit(1'b1);
      chk("final_drained", exp_q.size(), 0);
      chk("final_out", {24'd0, data_out}, 32'hFF);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
